// File: rtl/pyhdl_if_call_arb_pkg.sv
// Shared types for the pyhdl_if call arbiter.
// Fields are sized for the widest supported payload.
package pyhdl_if_call_arb_pkg;

  localparam int CALL_METHOD_W = 16;
  localparam int CALL_DATA_W   = 128;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DELIVER
  } state_t;

  typedef struct packed {
    logic [CALL_METHOD_W-1:0] method;
    logic [CALL_DATA_W-1:0]   data;
  } call_req_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pyhdl_if_call_arb_if.sv
// Requester, bridge and response channels of the call arbiter.
// master: arbiter side, slave: requesters and bridge.
interface pyhdl_if_call_arb_if
  import pyhdl_if_call_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 64,
  parameter int METHOD_W = 8
) ();

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ-1:0]          req_ready;
  logic [N_REQ*METHOD_W-1:0] req_method;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic                      call_valid;
  logic                      call_ready;
  logic [METHOD_W-1:0]       call_method;
  logic [DATA_W-1:0]         call_data;
  logic [IW-1:0]             call_src;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [N_REQ-1:0]          up_rsp_valid;
  logic [N_REQ-1:0]          up_rsp_ready;
  logic [DATA_W-1:0]         up_rsp_data;
  logic                      up_rsp_err;
  logic                      busy;

  modport master (
    input  req_valid, req_method, req_data,
    input  call_ready, rsp_valid, rsp_data,
    input  up_rsp_ready,
    output req_ready, call_valid, call_method,
    output call_data, call_src, rsp_ready,
    output up_rsp_valid, up_rsp_data,
    output up_rsp_err, busy
  );

  modport slave (
    output req_valid, req_method, req_data,
    output call_ready, rsp_valid, rsp_data,
    output up_rsp_ready,
    input  req_ready, call_valid, call_method,
    input  call_data, call_src, rsp_ready,
    input  up_rsp_valid, up_rsp_data,
    input  up_rsp_err, busy
  );

endinterface

// File: rtl/pyhdl_if_rr_pick.sv
// Rotating priority encoder: first set bit at or above ptr, with wrap.
module pyhdl_if_rr_pick
  import pyhdl_if_call_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan downward so the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pyhdl_if_call_arb.sv
// Round-robin arbiter sharing one blocking HDL->Python call channel.
// Define PYHDL_IF_CALL_ARB_TIMEOUT_EN to add the response watchdog.
module pyhdl_if_call_arb
  import pyhdl_if_call_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 64,
  parameter int METHOD_W = 8,
  parameter int TMO_W    = 16
) (
  input logic             clock,
  input logic             reset_n,
  pyhdl_if_call_arb_if.master bus
);

  localparam int IW = idx_w(N_REQ);

  if (TMO_W < 1 || N_REQ < 2 || N_REQ > 16) begin : g_bad_cfg
  end

  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       grant;
  logic [IW-1:0]       pick_idx;
  logic [IW-1:0]       nxt_ptr;
  logic                pick_found;
  logic [N_REQ-1:0]    pick_oh;
  logic [N_REQ-1:0]    grant_oh;
  logic [METHOD_W-1:0] sel_method;
  logic [DATA_W-1:0]   sel_data;
  call_req_t           req_q;
  logic                call_valid_q;
  logic                rsp_ready_q;
  logic                busy_q;
  logic [N_REQ-1:0]    up_valid_q;
  logic [DATA_W-1:0]   rsp_q;

  pyhdl_if_rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign sel_method = bus.req_method[int'(pick_idx)*METHOD_W +: METHOD_W];
  assign sel_data   = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
  assign pick_oh    = N_REQ'(1) << pick_idx;
  assign grant_oh   = N_REQ'(1) << grant;
  assign nxt_ptr    = (int'(pick_idx) == N_REQ - 1) ? '0
                    : pick_idx + IW'(1);

  // Accept is combinational in IDLE; gated so reset shows no ready.
  assign bus.req_ready = (state == IDLE && pick_found && reset_n)
                       ? pick_oh : '0;

  assign bus.call_valid   = call_valid_q;
  assign bus.call_method  = METHOD_W'(req_q.method);
  assign bus.call_data    = DATA_W'(req_q.data);
  assign bus.call_src     = grant;
  assign bus.rsp_ready    = rsp_ready_q;
  assign bus.up_rsp_valid = up_valid_q;
  assign bus.up_rsp_data  = rsp_q;
  assign bus.busy         = busy_q;

`ifdef PYHDL_IF_CALL_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo;
  logic [TMO_W-1:0] tmo_nxt;
  logic             err_q;

  assign tmo_nxt        = tmo + TMO_W'(1);
  assign bus.up_rsp_err = err_q;
`else
  assign bus.up_rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant        <= '0;
      req_q        <= '0;
      call_valid_q <= 1'b0;
      rsp_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      up_valid_q   <= '0;
      rsp_q        <= '0;
`ifdef PYHDL_IF_CALL_ARB_TIMEOUT_EN
      tmo          <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            grant        <= pick_idx;
            req_q.method <= CALL_METHOD_W'(sel_method);
            req_q.data   <= CALL_DATA_W'(sel_data);
            rr_ptr       <= nxt_ptr;
            call_valid_q <= 1'b1;
            busy_q       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.call_ready) begin
            call_valid_q <= 1'b0;
            rsp_ready_q  <= 1'b1;
            state        <= WAIT;
`ifdef PYHDL_IF_CALL_ARB_TIMEOUT_EN
            tmo          <= '0;
`endif
          end
        end
        WAIT: begin
          if (bus.rsp_valid) begin
            rsp_q       <= bus.rsp_data;
            rsp_ready_q <= 1'b0;
            up_valid_q  <= grant_oh;
            state       <= DELIVER;
`ifdef PYHDL_IF_CALL_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (&tmo_nxt) begin
            rsp_q       <= '0;
            err_q       <= 1'b1;
            rsp_ready_q <= 1'b0;
            up_valid_q  <= grant_oh;
            state       <= DELIVER;
          end else begin
            tmo         <= tmo_nxt;
`endif
          end
        end
        DELIVER: begin
          if (bus.up_rsp_ready[grant]) begin
            up_valid_q <= '0;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pyhdl_if_call_arb.sv
// Directed self-checking bench for pyhdl_if_call_arb.
module tb_pyhdl_if_call_arb;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  pyhdl_if_call_arb_if #(
    .N_REQ(4), .DATA_W(64), .METHOD_W(8)
  ) bus ();

  pyhdl_if_call_arb #(
    .N_REQ(4), .DATA_W(64), .METHOD_W(8), .TMO_W(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i,
                         input logic [7:0] m,
                         input logic [63:0] d);
    bus.req_method[i*8 +: 8] = m;
    bus.req_data[i*64 +: 64] = d;
  endtask

  task automatic do_call(input int src,
                         input logic [7:0] m,
                         input logic [63:0] d,
                         input logic [63:0] r);
    logic [3:0] oh;
    oh = 4'b0001 << src;
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("grant", bus.req_ready, oh);
    tick();
    chk("issue_busy", bus.busy, 1);
    chk("call_valid", bus.call_valid, 1);
    chk("call_src", bus.call_src, src);
    chk("call_method", bus.call_method, m);
    chk("call_data", bus.call_data, d);
    bus.call_ready = 1;
    tick();
    bus.call_ready = 0;
    chk("wait_rsp_ready", bus.rsp_ready, 1);
    bus.rsp_valid = 1;
    bus.rsp_data  = r;
    tick();
    bus.rsp_valid = 0;
    chk("up_rsp_valid", bus.up_rsp_valid, oh);
    chk("up_rsp_data", bus.up_rsp_data, r);
    chk("up_rsp_err", bus.up_rsp_err, 0);
    bus.up_rsp_ready = oh;
    tick();
    bus.up_rsp_ready = 0;
    chk("done_up_valid", bus.up_rsp_valid, 0);
  endtask

  initial begin
    clock            = 0;
    reset_n          = 1;
    bus.req_valid    = '0;
    bus.req_method   = '0;
    bus.req_data     = '0;
    bus.call_ready   = 0;
    bus.rsp_valid    = 0;
    bus.rsp_data     = '0;
    bus.up_rsp_ready = '0;

    // Reset state, with requests pending
    #1 reset_n = 0;
    bus.req_valid = 4'b1111;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_call_valid", bus.call_valid, 0);
    chk("rst_rsp_ready", bus.rsp_ready, 0);
    chk("rst_up_valid", bus.up_rsp_valid, 0);
    chk("rst_err", bus.up_rsp_err, 0);
    chk("rst_call_src", bus.call_src, 0);
    chk("rst_call_method", bus.call_method, 0);
    chk("rst_call_data", bus.call_data, 0);
    chk("rst_up_data", bus.up_rsp_data, 0);
    bus.req_valid = '0;
    reset_n = 1;
    tick();

    // Single call from requester 2, valid dropped after accept
    set_req(2, 8'h05, 64'hA5);
    bus.req_valid = 4'b0100;
    #1;
    chk("s_req_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    #1;
    chk("s_call_valid", bus.call_valid, 1);
    chk("s_call_src", bus.call_src, 2);
    chk("s_call_method", bus.call_method, 8'h05);
    chk("s_call_data", bus.call_data, 64'hA5);
    chk("s_req_ready_issue", bus.req_ready, 0);
    bus.call_ready = 1;
    tick();
    bus.call_ready = 0;
    chk("s_call_valid_off", bus.call_valid, 0);
    chk("s_rsp_ready", bus.rsp_ready, 1);
    bus.rsp_valid = 1;
    bus.rsp_data  = 64'h77;
    tick();
    bus.rsp_valid = 0;
    chk("s_up_valid", bus.up_rsp_valid, 4'b0100);
    chk("s_up_data", bus.up_rsp_data, 64'h77);
    chk("s_rsp_ready_off", bus.rsp_ready, 0);
    bus.up_rsp_ready = 4'b0100;
    tick();
    bus.up_rsp_ready = 0;
    chk("s_idle_busy", bus.busy, 0);

    // Wrap and skip: ptr=3, only req 1 valid
    for (int i = 0; i < 4; i++)
      set_req(i, 8'h10 + 8'(i), 64'h1000 + 64'(i));
    bus.req_valid = 4'b0010;
    do_call(1, 8'h11, 64'h1001, 64'hB1);
    // ptr now 2
    bus.req_valid = 4'b1111;
    do_call(2, 8'h12, 64'h1002, 64'hB2);

    // Backpressure on call and response, grant 3
    #1;
    chk("bp_grant", bus.req_ready, 4'b1000);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.rsp_valid    = (i < 3);
      bus.up_rsp_ready = 4'b0111;
      #1;
      chk("bp_call_valid", bus.call_valid, 1);
      chk("bp_call_src", bus.call_src, 3);
      chk("bp_call_data", bus.call_data, 64'h1003);
      chk("bp_rsp_ready", bus.rsp_ready, 0);
      chk("bp_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.rsp_valid  = 0;
    bus.call_ready = 1;
    tick();
    bus.call_ready = 0;
    chk("bp_wait", bus.rsp_ready, 1);
    bus.rsp_valid = 1;
    bus.rsp_data  = 64'h88;
    tick();
    bus.rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_up_valid", bus.up_rsp_valid, 4'b1000);
      chk("bp_up_data", bus.up_rsp_data, 64'h88);
      chk("bp_deliver_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.up_rsp_ready = 4'b1000;
    tick();
    bus.up_rsp_ready = 0;
    chk("bp_release", bus.up_rsp_valid, 0);

    // Reset in the middle of WAIT
    #1;
    chk("rw_grant", bus.req_ready, 4'b0001);
    tick();
    bus.call_ready = 1;
    tick();
    bus.call_ready = 0;
    chk("rw_in_wait", bus.rsp_ready, 1);
    reset_n = 0;
    #1;
    chk("rw_call_valid", bus.call_valid, 0);
    chk("rw_rsp_ready", bus.rsp_ready, 0);
    chk("rw_busy", bus.busy, 0);
    chk("rw_req_ready", bus.req_ready, 0);
    chk("rw_call_data", bus.call_data, 0);
    bus.req_valid = '0;
    bus.rsp_valid = 1;
    bus.rsp_data  = 64'h99;
    @(posedge clock);
    #1 reset_n = 1;
    tick();
    chk("rw_stray_rsp_ready", bus.rsp_ready, 0);
    chk("rw_stray_busy", bus.busy, 0);
    tick();
    chk("rw_no_delivery", bus.up_rsp_valid, 0);
    bus.rsp_valid = 0;

    // Fairness: all valid, grants rotate from 0
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++)
      do_call(k % 4, 8'h10 + 8'(k % 4),
              64'h1000 + 64'(k % 4), 64'h5000 + 64'(k));

`ifdef PYHDL_IF_CALL_ARB_TIMEOUT_EN
    // Watchdog expiry then a normal call
    bus.req_valid = 4'b0010;
    #1;
    chk("t_grant", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid  = '0;
    bus.call_ready = 1;
    tick();
    bus.call_ready = 0;
    for (int i = 0; i < 15; i++) begin
      chk("t_wait_rsp_ready", bus.rsp_ready, 1);
      chk("t_wait_up_valid", bus.up_rsp_valid, 0);
      tick();
    end
    chk("t_up_valid", bus.up_rsp_valid, 4'b0010);
    chk("t_err", bus.up_rsp_err, 1);
    chk("t_data", bus.up_rsp_data, 0);
    chk("t_rsp_ready", bus.rsp_ready, 0);
    bus.rsp_valid    = 1;
    bus.rsp_data     = 64'hDEAD;
    bus.up_rsp_ready = 4'b0010;
    tick();
    bus.up_rsp_ready = 0;
    chk("t_late_rsp", bus.rsp_ready, 0);
    bus.rsp_valid = 0;
    bus.req_valid = 4'b0100;
    do_call(2, 8'h12, 64'h1002, 64'h66);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pyhdl_if_call_arb.md
Name: pyhdl_if_call_arb

Overview:
- Shares one HDL→Python call channel among N_REQ HDL requesters.
- Python-side calls are blocking, so only one call is outstanding at a time.
- Arbitrates round-robin, forwards the winning request with its source index, and routes the single response back to the granted requester.
- Sits between per-agent call ports and the pyhdl_if bridge endpoint in the VIA layer.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 64, call/response payload width.
- METHOD_W, 8, method-id width.
- TMO_W, 16, watchdog counter width (used only when the optional feature is compiled in).

Ports:
- clock  in  1  single clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester call request.
- req_ready  out  N_REQ  per-requester accept.
- req_method  in  N_REQ*METHOD_W  packed method ids; requester i occupies bits [i*METHOD_W +: METHOD_W].
- req_data  in  N_REQ*DATA_W  packed payloads, same packing.
- call_valid  out  1  request to bridge.
- call_ready  in  1  bridge accept.
- call_method  out  METHOD_W  forwarded method id.
- call_data  out  DATA_W  forwarded payload.
- call_src  out  $clog2(N_REQ)  granted requester index.
- rsp_valid  in  1  bridge response.
- rsp_ready  out  1  response accept.
- rsp_data  in  DATA_W  response payload.
- up_rsp_valid  out  N_REQ  one-hot response to requesters.
- up_rsp_ready  in  N_REQ  requester response accept.
- up_rsp_data  out  DATA_W  response payload, broadcast to all requesters.
- up_rsp_err  out  1  response is a timeout error.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert use):
  - FSM=IDLE, rr_ptr=0, grant=0.
  - All valid/ready outputs 0; call_method, call_data, call_src, up_rsp_data, up_rsp_err all 0.
  - busy=0.
- IDLE:
  - If any req_valid, pick the first set bit scanning from rr_ptr upward with wrap.
  - Latch grant index, method and data into registers.
  - Pulse req_ready[grant]=1 for exactly one cycle; that cycle is the accept.
  - Go to ISSUE.
  - rr_ptr ← grant+1, wrapping to 0 after N_REQ-1.
- ISSUE:
  - call_valid=1 with the registered fields; the fields stay stable while call_ready=0.
  - On call_valid&&call_ready, go to WAIT.
- WAIT:
  - rsp_ready=1.
  - On rsp_valid, latch rsp_data into up_rsp_data, set up_rsp_err=0, go to DELIVER.
- DELIVER:
  - up_rsp_valid[grant]=1, data held stable.
  - On up_rsp_ready[grant], go to IDLE; a new grant is possible the following cycle.
- Latency: request accept→call_valid is 1 cycle; rsp handshake→up_rsp_valid is 1 cycle.
- Minimum turnaround is 4 cycles per call.
- Boundary conditions:
  - req_ready is never asserted outside IDLE.
  - A requester dropping req_valid after acceptance has no effect.
  - All N_REQ valid continuously: grants rotate 0,1,..,N-1,0.
  - A single requester valid continuously: granted every round.
  - rsp_valid seen outside WAIT is ignored (rsp_ready=0).
  - up_rsp_ready on non-granted lines is ignored.
  - Reset mid-call abandons the call; no response is delivered.

Optional Feature:
- Macro: PYHDL_IF_CALL_ARB_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit counter clears on entering WAIT and increments each WAIT cycle.
  - On reaching all-ones without rsp_valid, go to DELIVER with up_rsp_data=0, up_rsp_err=1.
  - A late rsp_valid after that point is dropped; rsp_ready stays 0.
  - If rsp_valid and expiry happen in the same cycle, the response wins.
- Undefined: no counter; up_rsp_err is tied 0; WAIT lasts indefinitely.

Decomposition:
- Package pyhdl_if_call_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DELIVER);
  - the localparam function for index width;
  - the call_req_t struct {method, data}.
- One sub-module: pyhdl_if_rr_pick, a combinational rotate-priority-encoder taking req vector and ptr and returning idx and found.

Test Plan:
- Single call: req_valid[2]=1, method=8'h05, data=64'hA5 → call_src=2, call_method=5, call_data=64'hA5 one cycle after accept. Then rsp_data=64'h77 → up_rsp_valid=4'b0100, up_rsp_data=64'h77.
- Fairness: all four valid for 8 calls → grant order 0,1,2,3,0,1,2,3. busy deasserts for exactly one cycle between calls.
- Backpressure: call_ready=0 for 5 cycles → call_valid and fields stable for all 5. up_rsp_ready low for 3 cycles → up_rsp_valid held; no new req_ready during that time.
- Wrap and skip: rr_ptr=3 with only req 1 valid → grant 1, then rr_ptr=2.
- Reset mid-WAIT: assert reset_n=0 → all outputs 0 immediately. A stray rsp_valid after deassert is not accepted.
- With PYHDL_IF_CALL_ARB_TIMEOUT_EN and TMO_W=4: no response → up_rsp_err=1 after 15 WAIT cycles. A late rsp_valid is not accepted while the next call proceeds normally.
